// File: rtl/mult_arbiter_pkg.sv
// Shared state encodings and helpers for the mult_arbiter slice.
package mult_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } state_t;

    // Upper bound on requester count supported by the index helper.
    localparam int MAX_REQ = 32;
    localparam int MAX_ID  = 5;

    function automatic logic [MAX_ID-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
        logic [MAX_ID-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (onehot[i]) begin
                idx = idx | MAX_ID'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mult_arbiter_rr.sv
// Combinational grant picker: round-robin from ptr when MULT_ARBITER_RR_EN is
// defined, otherwise fixed priority with the lowest index winning.
module mult_arbiter_rr
    import mult_arbiter_pkg::*;
#(
    parameter int NB_REQ = 4,
    parameter int NB_ID  = $clog2(NB_REQ)
) (
    input  logic [NB_REQ-1:0] valid,
    input  logic [NB_ID-1:0]  ptr,
    output logic [NB_REQ-1:0] grant,
    output logic [NB_ID-1:0]  grant_idx,
    output logic              grant_any
);

    int                start_s;
    logic [NB_REQ-1:0] grant_s;

`ifdef MULT_ARBITER_RR_EN
    assign start_s = int'(ptr);
`else
    logic unused_ptr_s;
    assign unused_ptr_s = ^ptr;
    assign start_s      = 32'sd0;
`endif

    // Scan from the start index and keep only the first valid found.
    always_comb begin
        grant_s = '0;
        for (int i = 0; i < NB_REQ; i++) begin
            if ((grant_s == '0) && valid[NB_ID'((start_s + i) % NB_REQ)]) begin
                grant_s[NB_ID'((start_s + i) % NB_REQ)] = 1'b1;
            end else begin
                grant_s = grant_s;
            end
        end
    end

    assign grant     = grant_s;
    assign grant_idx = NB_ID'(onehot_to_idx(MAX_REQ'(grant_s)));
    assign grant_any = |valid;

endmodule

// File: rtl/mult_arbiter.sv
// Shares one signed radix-2 shift-add multiplier among NB_REQ requesters.
// Define MULT_ARBITER_RR_EN for round-robin arbitration (fixed priority otherwise).
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int NB_DATA = 4,
    parameter int NB_REQ  = 4,
    parameter int NB_ID   = $clog2(NB_REQ)
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [NB_REQ-1:0]         i_req_valid,
    output logic [NB_REQ-1:0]         o_req_ready,
    input  logic [NB_REQ*NB_DATA-1:0] i_a,
    input  logic [NB_REQ*NB_DATA-1:0] i_b,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [2*NB_DATA-1:0]      o_product,
    output logic [NB_ID-1:0]          o_id,
    output logic                      o_busy
);

    localparam int                NB_CNT   = $clog2(NB_DATA);
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_DATA - 1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic                load_s;
    logic                step_s;

    logic [NB_REQ-1:0]   grant_s;
    logic [NB_ID-1:0]    grant_idx_s;
    logic                grant_any_s;
    logic [NB_ID-1:0]    ptr_s;

    logic [NB_DATA-1:0]  a_r;
    logic [NB_DATA-1:0]  h_r;
    logic [NB_DATA-1:0]  l_r;
    logic [NB_CNT-1:0]   cnt_r;
    logic [NB_ID-1:0]    id_r;

    logic [NB_DATA-1:0]  a_sel_s;
    logic [NB_DATA-1:0]  b_sel_s;
    logic [NB_DATA:0]    h_ext_s;
    logic [NB_DATA:0]    addend_s;
    logic [NB_DATA:0]    sum_s;
    logic                last_s;

    mult_arbiter_rr #(
        .NB_REQ (NB_REQ),
        .NB_ID  (NB_ID)
    ) u_rr (
        .valid     (i_req_valid),
        .ptr       (ptr_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .grant_any (grant_any_s)
    );

`ifdef MULT_ARBITER_RR_EN
    logic [NB_ID-1:0] ptr_r;

    // Round-robin pointer moves just past the requester granted last.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr_r <= '0;
        end else if (load_s) begin
            ptr_r <= (grant_idx_s == NB_ID'(NB_REQ - 1)) ? '0 : grant_idx_s + NB_ID'(1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    assign ptr_s = ptr_r;
`else
    assign ptr_s = '0;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic with load/step strobes for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (grant_any_s) begin
                    load_s      = 1'b1;
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                step_s = 1'b1;
                if (last_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign a_sel_s = i_a[int'(grant_idx_s)*NB_DATA +: NB_DATA];
    assign b_sel_s = i_b[int'(grant_idx_s)*NB_DATA +: NB_DATA];

    // The final step subtracts because the multiplier MSB carries negative weight.
    assign last_s   = (cnt_r == CNT_LAST);
    assign h_ext_s  = {h_r[NB_DATA-1], h_r};
    assign addend_s = l_r[0] ? {a_r[NB_DATA-1], a_r} : '0;
    assign sum_s    = last_s ? (h_ext_s - addend_s) : (h_ext_s + addend_s);

    // Operand capture on grant, then one add/shift step per RUN cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_r   <= '0;
            h_r   <= '0;
            l_r   <= '0;
            cnt_r <= '0;
            id_r  <= '0;
        end else if (load_s) begin
            a_r   <= a_sel_s;
            h_r   <= '0;
            l_r   <= b_sel_s;
            cnt_r <= '0;
            id_r  <= grant_idx_s;
        end else if (step_s) begin
            h_r   <= sum_s[NB_DATA:1];
            l_r   <= {sum_s[0], l_r[NB_DATA-1:1]};
            cnt_r <= cnt_r + NB_CNT'(1);
        end else begin
            a_r   <= a_r;
            h_r   <= h_r;
            l_r   <= l_r;
            cnt_r <= cnt_r;
            id_r  <= id_r;
        end
    end

    assign o_req_ready = load_s ? grant_s : '0;
    assign o_valid     = (state_r == DONE);
    assign o_busy      = (state_r == RUN) || (state_r == DONE);
    assign o_product   = {h_r, l_r};
    assign o_id        = id_r;

endmodule
